// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : io_bus_arbiter
// Purpose : Round-robin arbiter sharing the I/O port register bus between
//           the CPU (master 0) and the peripheral sequencer (master 1).
// Revision: 1.0  initial release
// ============================================================================
module io_bus_arbiter #(
    parameter logic [3:0] M1_WR_MASK = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [1:0] m0_adrs,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,

    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [1:0] m1_adrs,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       m1_err,

    output logic [1:0] io_adrs,
    output logic [7:0] io_din,
    input  logic [7:0] io_dout,
    output logic       io_rd,
    output logic       io_wr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic       r_id;
    logic       r_we;
    logic       r_err;

    logic       w_grant;
    logic       w_gid;
    logic       w_we;
    logic [1:0] w_adrs;
    logic [7:0] w_wdata;
    logic       w_blocked;

    // In DONE only the other master may be granted; the just-acked master's
    // req is still high from the old transaction and must not be re-served.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant = 1'b1;
                    w_gid   = (m0_req && m1_req) ? ~r_last : m1_req;
                    w_next  = ACCESS;
                end
            end
            ACCESS: begin
                w_next = DONE;
            end
            DONE: begin
                if (r_id ? m0_req : m1_req) begin
                    w_grant = 1'b1;
                    w_gid   = ~r_id;
                    w_next  = ACCESS;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_we      = w_gid ? m1_we    : m0_we;
    assign w_adrs    = w_gid ? m1_adrs  : m0_adrs;
    assign w_wdata   = w_gid ? m1_wdata : m0_wdata;
    assign w_blocked = w_gid & w_we & ~M1_WR_MASK[w_adrs];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are set on the edge that enters ACCESS so the bus sees them
    // registered for exactly that one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            io_adrs  <= 2'd0;
            io_din   <= 8'd0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= 8'd0;
            m1_rdata <= 8'd0;
        end else begin
            io_rd  <= 1'b0;
            io_wr  <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            if (w_grant) begin
                r_last  <= w_gid;
                r_id    <= w_gid;
                r_we    <= w_we;
                r_err   <= w_blocked;
                io_adrs <= w_adrs;
                io_din  <= w_wdata;
                io_rd   <= ~w_we;
                io_wr   <= w_we & ~w_blocked;
            end
            if (r_state == ACCESS) begin
                m0_ack <= ~r_id;
                m1_ack <= r_id;
                m1_err <= r_id & r_err;
                if (!r_we) begin
                    if (r_id) begin
                        m1_rdata <= io_dout;
                    end else begin
                        m0_rdata <= io_dout;
                    end
                end
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// Testbench for io_bus_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-schedule model.
module tb_io_bus_arbiter;

    localparam logic [3:0] C_MASK = 4'b1000;

    logic       clk;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [1:0] m0_adrs, m1_adrs;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_ack, m1_ack, m1_err;
    logic [7:0] m0_rdata, m1_rdata;
    logic [1:0] io_adrs;
    logic [7:0] io_din, io_dout;
    logic       io_rd, io_wr, busy;

    io_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adrs(m0_adrs), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adrs(m1_adrs), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .io_adrs(io_adrs), .io_din(io_din), .io_dout(io_dout),
        .io_rd(io_rd), .io_wr(io_wr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a transaction is granted at edge g; the bus access is visible
    // after edge g, the ack after edge g+1.  The other master can be granted
    // at g+2, anyone (fair tie-break) from g+3 on.
    int         e      = 0;
    int         g      = -100;
    int         m_last = 1;
    int         t_m    = 0;
    logic       t_we, t_blk;
    logic [1:0] t_adrs, h_adrs;
    logic [7:0] t_wd, h_din;
    logic       x_rd, x_wr, x_ack0, x_ack1, x_err, x_busy;
    logic [7:0] x_rdata0, x_rdata1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    endtask

    task automatic model_edge();
        int d;
        bit grant;
        int w;
        e++;
        x_rd = 0; x_wr = 0; x_ack0 = 0; x_ack1 = 0; x_err = 0; x_busy = 0;
        if (!rst) begin
            g = -100; m_last = 1; h_adrs = 2'd0; h_din = 8'd0;
            x_rdata0 = 8'd0; x_rdata1 = 8'd0;
            return;
        end
        d = e - g;
        grant = 0;
        w = 0;
        if (d == 2) begin
            if ((t_m == 0) ? m1_req : m0_req) begin grant = 1; w = 1 - t_m; end
        end else if (d >= 3) begin
            if (m0_req && m1_req) begin grant = 1; w = 1 - m_last; end
            else if (m0_req || m1_req) begin grant = 1; w = m1_req ? 1 : 0; end
        end
        if (grant) begin
            g = e; t_m = w; m_last = w;
            t_we   = (w == 1) ? m1_we    : m0_we;
            t_adrs = (w == 1) ? m1_adrs  : m0_adrs;
            t_wd   = (w == 1) ? m1_wdata : m0_wdata;
            t_blk  = (w == 1) && t_we && !C_MASK[t_adrs];
            h_adrs = t_adrs; h_din = t_wd;
        end
        if (e == g) begin
            x_rd = !t_we; x_wr = t_we && !t_blk; x_busy = 1;
        end else if (e == g + 1) begin
            x_busy = 1;
            if (t_m == 1) begin x_ack1 = 1; x_err = t_blk; end
            else          x_ack0 = 1;
            if (!t_we) begin
                if (t_m == 1) x_rdata1 = io_dout;
                else          x_rdata0 = io_dout;
            end
        end
    endtask

    task automatic check_all();
        chk("io_rd",    8'(io_rd),   8'(x_rd));
        chk("io_wr",    8'(io_wr),   8'(x_wr));
        chk("io_adrs",  8'(io_adrs), 8'(h_adrs));
        chk("io_din",   io_din,      h_din);
        chk("m0_ack",   8'(m0_ack),  8'(x_ack0));
        chk("m1_ack",   8'(m1_ack),  8'(x_ack1));
        chk("m1_err",   8'(m1_err),  8'(x_err));
        chk("m0_rdata", m0_rdata,    x_rdata0);
        chk("m1_rdata", m1_rdata,    x_rdata1);
        chk("busy",     8'(busy),    8'(x_busy));
        chk("rd_wr_excl", 8'(io_rd & io_wr), 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic set_m(input int m, input logic req, input logic we,
                         input logic [1:0] adrs, input logic [7:0] wd);
        if (m == 0) begin m0_req = req; m0_we = we; m0_adrs = adrs; m0_wdata = wd; end
        else        begin m1_req = req; m1_we = we; m1_adrs = adrs; m1_wdata = wd; end
    endtask

    initial begin
        int a0, a1, first, last_s;
        bit act0, act1;
        rst = 1'b0; io_dout = 8'd0;
        set_m(0, 0, 0, 2'd0, 8'd0);
        set_m(1, 0, 0, 2'd0, 8'd0);
        step(); step();
        rst = 1'b1;
        step();

        // m0 write adrs 3 / 0x5A
        set_m(0, 1, 1, 2'd3, 8'h5A);
        step();
        chk("t1_wr", 8'(io_wr), 8'd1);
        chk("t1_adrs", 8'(io_adrs), 8'd3);
        chk("t1_din", io_din, 8'h5A);
        step();
        chk("t1_ack", 8'(m0_ack), 8'd1);
        chk("t1_wr_gone", 8'(io_wr), 8'd0);
        chk("t1_m1ack", 8'(m1_ack), 8'd0);
        set_m(0, 0, 0, 2'd0, 8'd0);
        step();

        // m1 read adrs 0 with io_dout = 0x70
        io_dout = 8'h70;
        set_m(1, 1, 0, 2'd0, 8'd0);
        step();
        chk("t2_rd", 8'(io_rd), 8'd1);
        step();
        chk("t2_ack", 8'(m1_ack), 8'd1);
        chk("t2_rdata", m1_rdata, 8'h70);
        set_m(1, 0, 0, 2'd0, 8'd0);
        io_dout = 8'h11;
        step(); step();
        chk("t2_hold", m1_rdata, 8'h70);

        // both masters requesting continuously: alternating grants
        set_m(0, 1, 1, 2'd2, 8'h33);
        set_m(1, 1, 0, 2'd1, 8'd0);
        io_dout = 8'hC4;
        a0 = 0; a1 = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m0_ack) begin a0++; if (first < 0) first = 0; end
            if (m1_ack) begin a1++; if (first < 0) first = 1; end
        end
        chk("t3_m0_acks", 8'(a0), 8'd3);
        chk("t3_m1_acks", 8'(a1), 8'd3);
        chk("t3_first", 8'(first), 8'd0);
        set_m(0, 0, 0, 2'd0, 8'd0);
        set_m(1, 0, 0, 2'd0, 8'd0);
        step(); step();

        // m1 write blocked by the mask, then a permitted one
        set_m(1, 1, 1, 2'd1, 8'hFF);
        step();
        chk("t4_no_wr", 8'(io_wr), 8'd0);
        step();
        chk("t4_ack", 8'(m1_ack), 8'd1);
        chk("t4_err", 8'(m1_err), 8'd1);
        set_m(1, 1, 1, 2'd3, 8'h44);
        step(); step();
        chk("t4_wr", 8'(io_wr), 8'd1);
        step();
        chk("t4_ack2", 8'(m1_ack), 8'd1);
        chk("t4_err2", 8'(m1_err), 8'd0);
        set_m(1, 0, 0, 2'd0, 8'd0);

        // single master holding req: one access every 3 cycles
        set_m(0, 1, 0, 2'd2, 8'd0);
        last_s = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (io_rd) begin
                if (last_s >= 0) chk("t5_gap", 8'(e - last_s), 8'd3);
                last_s = e;
            end
        end
        set_m(0, 0, 0, 2'd0, 8'd0);
        step(); step(); step();

        // asynchronous reset during an m0 read access
        set_m(0, 1, 0, 2'd1, 8'd0);
        step();
        chk("t6_rd", 8'(io_rd), 8'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_rd", 8'(io_rd), 8'd0);
        chk("t6_rst_adrs", 8'(io_adrs), 8'd0);
        chk("t6_rst_busy", 8'(busy), 8'd0);
        chk("t6_rst_rdata", m0_rdata, 8'd0);
        set_m(0, 0, 0, 2'd0, 8'd0);
        step();
        chk("t6_no_ack", 8'(m0_ack), 8'd0);
        rst = 1'b1;
        set_m(0, 1, 0, 2'd2, 8'd0);
        set_m(1, 1, 0, 2'd0, 8'd0);
        step();
        chk("t6_m0_wins", 8'(io_adrs), 8'd2);
        step();
        chk("t6_m0_ack", 8'(m0_ack), 8'd1);
        set_m(0, 0, 0, 2'd0, 8'd0);
        step();
        set_m(1, 0, 0, 2'd0, 8'd0);
        step(); step(); step();

        // random traffic from both masters
        act0 = 0; act1 = 0;
        for (int i = 0; i < 500; i++) begin
            io_dout = 8'($urandom);
            if (act0 && x_ack0) begin
                if ($urandom_range(0, 1) == 1)
                    set_m(0, 1, 1'($urandom), 2'($urandom), 8'($urandom));
                else begin act0 = 0; set_m(0, 0, 0, 2'd0, 8'd0); end
            end else if (!act0 && $urandom_range(0, 2) == 0) begin
                act0 = 1;
                set_m(0, 1, 1'($urandom), 2'($urandom), 8'($urandom));
            end
            if (act1 && x_ack1) begin
                if ($urandom_range(0, 1) == 1)
                    set_m(1, 1, 1'($urandom), 2'($urandom), 8'($urandom));
                else begin act1 = 0; set_m(1, 0, 0, 2'd0, 8'd0); end
            end else if (!act1 && $urandom_range(0, 2) == 0) begin
                act1 = 1;
                set_m(1, 1, 1'($urandom), 2'($urandom), 8'($urandom));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
